opb_mcnt_snapshot_ctrl: RTL and testbench



---
 rtl/opb_mcnt_pkg.sv | 33 +++
 rtl/opb_slave_handshake.sv | 64 ++++++
 rtl/opb_mcnt_snapshot_ctrl.sv | 145 ++++++++++++++
 tb/tb_opb_mcnt_snapshot_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_mcnt_pkg.sv
// Shared constants and types for the OPB mcnt snapshot controller.
// Bit positions use LSB=0 numbering: OPB big-endian bit n is value bit 31-n.
package opb_mcnt_pkg;

    localparam logic [7:0] OFF_MSB    = 8'h00;
    localparam logic [7:0] OFF_LSB    = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    localparam int CTRL_FREEZE_BIT = 0;
    localparam int CTRL_ARM_BIT    = 1;
    localparam int STAT_VALID_BIT  = 0;
    localparam int STAT_TEAR_BIT   = 1;
    localparam int STAT_CNT_LSB    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } hs_state_t;

    function automatic logic [31:0] pack_status(input logic [15:0] cnt,
                                                input logic        tear,
                                                input logic        valid);
        logic [31:0] w_word;
        w_word = '0;
        w_word[STAT_CNT_LSB +: 16] = cnt;
        w_word[STAT_TEAR_BIT]      = tear;
        w_word[STAT_VALID_BIT]     = valid;
        return w_word;
    endfunction

endpackage

// File: rtl/opb_slave_handshake.sv
// OPB slave address decode and single-beat handshake sequencer.
//   state   | meaning
//   IDLE    | waiting for a select inside the window; strobes fire here
//   ACK     | one-cycle xferAck with registered read data
//   HOLD    | dead cycle so a lingering select cannot be acked twice
module opb_slave_handshake
    import opb_mcnt_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01008200,
    parameter logic [31:0] C_HIGHADDR = 32'h010082FF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [0:31] i_abus,
    input  logic        i_rnw,
    input  logic        i_select,
    output logic        o_rd_strobe,
    output logic        o_wr_strobe,
    output logic [7:0]  o_offset,
    output logic        o_ack
);

    hs_state_t  r_state;
    hs_state_t  w_state_nxt;
    logic       w_hit;
    logic [1:0] w_unused_lane;

    assign w_hit         = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);
    assign o_offset      = {i_abus[24:27], i_abus[28:29], 2'b00};
    assign w_unused_lane = i_abus[30:31];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_hit) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_HOLD;
            ST_HOLD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rd_strobe = 1'b0;
        o_wr_strobe = 1'b0;
        o_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_rd_strobe = w_hit && i_rnw;
                o_wr_strobe = w_hit && !i_rnw;
            end
            ST_ACK:  o_ack = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/opb_mcnt_snapshot_ctrl.sv
// Coherent 32-bit OPB view of the wide mcnt counter: an MSB read latches the
// LSB half into a shadow so the pair is never torn.
module opb_mcnt_snapshot_ctrl
    import opb_mcnt_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01008200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010082FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          MCNT_WIDTH   = 48
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [MCNT_WIDTH-1:0]   mcnt_in,
    input  logic                    mcnt_valid,
    output logic                    arm_out,
    output logic                    snap_pulse
);

    logic                  w_rd_strobe;
    logic                  w_wr_strobe;
    logic                  w_ack;
    logic [7:0]            w_offset;
    logic [31:0]           w_rd_data;
    logic [31:0]           w_ctrl_word;
    logic [63:0]           w_live_ext;
    logic [33:0]           w_unused;

    logic [MCNT_WIDTH-1:0] r_live;
    logic [31:0]           r_shadow;
    logic [31:0]           r_rdata;
    logic                  r_shadow_valid;
    logic                  r_tear;
    logic                  r_clr_tear;
    logic                  r_freeze;
    logic                  r_arm;
    logic                  r_snap;
    logic [15:0]           r_snap_cnt;

    opb_slave_handshake #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_hs (
        .i_clk       (OPB_Clk),
        .i_rst       (OPB_Rst),
        .i_abus      (OPB_ABus),
        .i_rnw       (OPB_RNW),
        .i_select    (OPB_select),
        .o_rd_strobe (w_rd_strobe),
        .o_wr_strobe (w_wr_strobe),
        .o_offset    (w_offset),
        .o_ack       (w_ack)
    );

    assign w_live_ext = 64'(r_live);
    assign w_unused   = {OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};

    always_comb begin
        w_ctrl_word                  = '0;
        w_ctrl_word[CTRL_FREEZE_BIT] = r_freeze;
        w_ctrl_word[CTRL_ARM_BIT]    = r_arm;
    end

    always_comb begin
        w_rd_data = '0;
        case (w_offset)
            OFF_MSB:    w_rd_data = w_live_ext[63:32];
            OFF_LSB:    w_rd_data = r_shadow;
            OFF_CTRL:   w_rd_data = w_ctrl_word;
            OFF_STATUS: w_rd_data = pack_status(r_snap_cnt, r_tear, r_shadow_valid);
            default:    w_rd_data = '0;
        endcase
    end

    // Snapshot and live update share an edge; the shadow takes the pre-update live value.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_live         <= '0;
            r_shadow       <= '0;
            r_rdata        <= '0;
            r_shadow_valid <= 1'b0;
            r_tear         <= 1'b0;
            r_clr_tear     <= 1'b0;
            r_freeze       <= 1'b0;
            r_arm          <= 1'b0;
            r_snap         <= 1'b0;
            r_snap_cnt     <= '0;
        end else begin
            r_snap <= 1'b0;
            if (mcnt_valid && !r_freeze) begin
                r_live <= mcnt_in;
            end
            if (w_rd_strobe) begin
                r_rdata <= w_rd_data;
                case (w_offset)
                    OFF_MSB: begin
                        r_shadow       <= w_live_ext[31:0];
                        r_shadow_valid <= 1'b1;
                        r_snap_cnt     <= r_snap_cnt + 16'd1;
                        r_snap         <= 1'b1;
                    end
                    OFF_LSB: begin
                        if (!r_shadow_valid) begin
                            r_tear <= 1'b1;
                        end
                        r_shadow_valid <= 1'b0;
                    end
                    OFF_STATUS: r_clr_tear <= 1'b1;
                    default: ;
                endcase
            end else if (w_wr_strobe) begin
                r_rdata <= '0;
                if (w_offset == OFF_CTRL && OPB_BE[3]) begin
                    r_freeze <= OPB_DBus[31-CTRL_FREEZE_BIT];
                    r_arm    <= OPB_DBus[31-CTRL_ARM_BIT];
                end
            end
            // tear_flag read-to-clear lands once the STATUS ack has gone out
            if (w_ack && r_clr_tear) begin
                r_tear     <= 1'b0;
                r_clr_tear <= 1'b0;
            end
        end
    end

    assign Sl_xferAck = w_ack;
    assign Sl_DBus    = w_ack ? r_rdata : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign arm_out    = r_arm;
    assign snap_pulse = r_snap;

endmodule

// File: tb/tb_opb_mcnt_snapshot_ctrl.sv
// Bench for opb_mcnt_snapshot_ctrl: directed register scenarios plus random bus
// traffic, all checked every cycle against a transaction-level model.
module tb_opb_mcnt_snapshot_ctrl;

    localparam logic [31:0] BASE = 32'h01008200;
    localparam logic [31:0] HIGH = 32'h010082FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] abus = '0;
    logic [0:3]  be = '0;
    logic [0:31] dbus = '0;
    logic        rnw = 1'b0;
    logic        sel = 1'b0;
    logic        seq = 1'b0;
    logic [0:31] sl_dbus;
    logic        sl_ack, sl_err, sl_retry, sl_tout;
    logic [47:0] mcnt_in = '0;
    logic        mcnt_valid = 1'b0;
    logic        arm_out, snap_pulse;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    opb_mcnt_snapshot_ctrl dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (sel),
        .OPB_seqAddr (seq),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (sl_ack),
        .Sl_errAck   (sl_err),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_tout),
        .mcnt_in     (mcnt_in),
        .mcnt_valid  (mcnt_valid),
        .arm_out     (arm_out),
        .snap_pulse  (snap_pulse)
    );

    // ---------------- transaction-level reference model ----------------
    logic [63:0] m_live = '0;
    logic [31:0] m_shadow = '0;
    bit          m_sv = 0, m_tear = 0, m_freeze = 0, m_arm = 0;
    int          m_cnt = 0;
    int          m_busy = 0;
    logic        exp_ack = 0, exp_snap = 0, exp_arm = 0;
    logic [31:0] exp_dbus = '0;

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  bev;
        logic [63:0] next_live;
        int          word;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_live = '0; m_shadow = '0; m_sv = 0; m_tear = 0;
                m_freeze = 0; m_arm = 0; m_cnt = 0; m_busy = 0;
                exp_ack = 0; exp_snap = 0; exp_arm = 0; exp_dbus = '0;
            end else begin
                a   = abus;
                wd  = dbus;
                bev = be;
                next_live = (mcnt_valid && !m_freeze) ? {16'h0, mcnt_in} : m_live;
                exp_ack = 0; exp_snap = 0; exp_dbus = '0;
                if (m_busy > 0) begin
                    m_busy--;
                end else if (sel && a >= BASE && a <= HIGH) begin
                    m_busy  = 2;
                    exp_ack = 1;
                    word = ((a & 32'hF0) == 0) ? int'((a >> 2) & 32'd3) : 4;
                    if (rnw) begin
                        case (word)
                            0: begin
                                exp_dbus = m_live[63:32];
                                m_shadow = m_live[31:0];
                                m_sv     = 1;
                                m_cnt    = (m_cnt + 1) % 65536;
                                exp_snap = 1;
                            end
                            1: begin
                                exp_dbus = m_shadow;
                                if (!m_sv) m_tear = 1;
                                m_sv = 0;
                            end
                            2: exp_dbus = 32'(int'(m_freeze) + 2 * int'(m_arm));
                            3: begin
                                exp_dbus = 32'(m_cnt * 65536 + 2 * int'(m_tear) + int'(m_sv));
                                m_tear = 0;
                            end
                            default: exp_dbus = '0;
                        endcase
                    end else if (word == 2 && (bev & 4'd1) != 0) begin
                        m_freeze = wd[0];
                        m_arm    = wd[1];
                    end
                end
                m_live  = next_live;
                exp_arm = m_arm;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            n_vec++;
            if (sl_ack !== exp_ack) begin
                n_err++; $display("FAIL xferAck t=%0t got %b expected %b", $time, sl_ack, exp_ack);
            end
            if (sl_dbus !== exp_dbus) begin
                n_err++; $display("FAIL Sl_DBus t=%0t got %h expected %h", $time, sl_dbus, exp_dbus);
            end
            if (snap_pulse !== exp_snap) begin
                n_err++; $display("FAIL snap_pulse t=%0t got %b expected %b", $time, snap_pulse, exp_snap);
            end
            if (arm_out !== exp_arm) begin
                n_err++; $display("FAIL arm_out t=%0t got %b expected %b", $time, arm_out, exp_arm);
            end
            if ({sl_err, sl_retry, sl_tout} !== 3'b000) begin
                n_err++; $display("FAIL tied_outputs t=%0t got %b expected 000", $time, {sl_err, sl_retry, sl_tout});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic rd_n, input logic [31:0] wd,
                        input logic [3:0] bev, output logic [31:0] rd, output logic snap);
        bit got;
        @(negedge clk);
        abus = a; rnw = rd_n; dbus = wd; be = bev; sel = 1'b1;
        got = 0; rd = '0; snap = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (sl_ack) begin
                got = 1; rd = sl_dbus; snap = snap_pulse;
            end
        end
        sel = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL ack_timeout: no ack for address %h within 8 cycles", a);
        end
    endtask

    task automatic rd32(input logic [7:0] off, output logic [31:0] rd, output logic snap);
        xfer(BASE + 32'(off), 1'b1, 32'h0, 4'hF, rd, snap);
    endtask

    task automatic wr32(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] bev);
        logic [31:0] rd;
        logic        sn;
        xfer(BASE + 32'(off), 1'b0, wd, bev, rd, sn);
    endtask

    task automatic pulse_mcnt(input logic [47:0] v);
        @(negedge clk);
        mcnt_in = v; mcnt_valid = 1'b1;
        @(negedge clk);
        mcnt_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        sn;
        int          acks, on_left, off_left, pick;

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rd32(8'h0C, rd, sn);         chk("status_after_reset", rd, 32'h0000_0000);

        pulse_mcnt(48'h1234_89ABCDEF);
        rd32(8'h00, rd, sn);         chk("msb_read", rd, 32'h0000_1234);
        chk("snap_on_msb", 32'(sn), 32'h1);
        rd32(8'h04, rd, sn);         chk("lsb_read", rd, 32'h89AB_CDEF);
        chk("no_snap_on_lsb", 32'(sn), 32'h0);
        rd32(8'h0C, rd, sn);         chk("status_count1", rd, 32'h0001_0000);

        rd32(8'h00, rd, sn);         chk("msb_before_change", rd, 32'h0000_1234);
        pulse_mcnt(48'h1235_00000000);
        rd32(8'h04, rd, sn);         chk("lsb_not_torn", rd, 32'h89AB_CDEF);
        rd32(8'h00, rd, sn);         chk("msb_after_change", rd, 32'h0000_1235);

        rd32(8'h04, rd, sn);         chk("lsb_shadow_zero", rd, 32'h0000_0000);
        rd32(8'h04, rd, sn);         chk("lsb_stale", rd, 32'h0000_0000);
        rd32(8'h0C, rd, sn);         chk("status_tear_set", rd, 32'h0003_0002);
        rd32(8'h0C, rd, sn);         chk("status_tear_cleared", rd, 32'h0003_0000);

        wr32(8'h08, 32'h0000_0001, 4'b0001);
        pulse_mcnt(48'hAAAA_BBBBCCCC);
        rd32(8'h00, rd, sn);         chk("msb_frozen", rd, 32'h0000_1235);
        rd32(8'h08, rd, sn);         chk("ctrl_freeze", rd, 32'h0000_0001);
        wr32(8'h08, 32'h0000_0000, 4'b1110);
        rd32(8'h08, rd, sn);         chk("ctrl_be_ignored", rd, 32'h0000_0001);
        wr32(8'h00, 32'hFFFF_FFFF, 4'b1111);
        wr32(8'h08, 32'h0000_0002, 4'b0001);
        chk("arm_set", 32'(arm_out), 32'h1);
        pulse_mcnt(48'hAAAA_BBBBCCCC);
        rd32(8'h00, rd, sn);         chk("msb_unfrozen", rd, 32'h0000_AAAA);
        rd32(8'h04, rd, sn);         chk("lsb_unfrozen", rd, 32'hBBBB_CCCC);
        rd32(8'h40, rd, sn);         chk("unmapped_read", rd, 32'h0000_0000);
        wr32(8'h08, 32'h0000_0000, 4'b0001);
        chk("arm_cleared", 32'(arm_out), 32'h0);

        // select held across accept, ACK and HOLD must yield a single ack
        @(negedge clk);
        abus = BASE + 32'h0C; rnw = 1'b1; sel = 1'b1; acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        chk("single_ack", 32'(acks), 32'd1);

        // reset during the ACK cycle of an MSB read
        @(negedge clk);
        abus = BASE; rnw = 1'b1; sel = 1'b1;
        @(negedge clk);
        chk("ack_before_reset", 32'(sl_ack), 32'h1);
        #2 rst = 1'b1; sel = 1'b0;
        #1;
        chk("ack_dropped_on_reset", 32'(sl_ack), 32'h0);
        chk("dbus_zero_on_reset", sl_dbus, 32'h0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        rd32(8'h0C, rd, sn);         chk("status_after_midreset", rd, 32'h0000_0000);
        rd32(8'h00, rd, sn);         chk("msb_after_midreset", rd, 32'h0000_0000);

        // random traffic with a moving counter
        on_left = 0; off_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            mcnt_valid = ($urandom_range(0, 3) != 0);
            mcnt_in    = {16'($urandom), 32'($urandom)};
            if (on_left > 0) on_left--;
            if (on_left == 0) begin
                if (sel) begin
                    sel = 1'b0;
                    off_left = $urandom_range(0, 3);
                end else if (off_left > 0) begin
                    off_left--;
                end else begin
                    pick = $urandom_range(0, 9);
                    case (pick)
                        6:       abus = BASE + 32'($urandom_range(4, 63)) * 4;
                        7:       abus = BASE + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(1, 3));
                        8:       abus = BASE - 4;
                        9:       abus = HIGH + 1;
                        default: abus = BASE + 32'($urandom_range(0, 3)) * 4;
                    endcase
                    rnw  = ($urandom_range(0, 2) != 0);
                    dbus = $urandom_range(0, 3);
                    be   = 4'($urandom_range(0, 15));
                    sel  = 1'b1;
                    on_left = $urandom_range(1, 4);
                end
            end
        end
        sel = 1'b0; mcnt_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
